// File: rtl/booth_product_display.sv
// Signed 12-bit product -> sign + 4-digit BCD (sequential double-dabble) -> scanned active-low 7-segment display.
// Optional BPD_LZ_BLANK_EN: blank leading zero magnitude digits (ones digit always shown).
module booth_product_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int PROD_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] product,
  input  logic              prod_valid,
  output logic              busy,
  output logic              done,
  output logic [7:0]        an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam int         RW      = $clog2(REFRESH_DIV);

  logic [1:0]        state_q, state_d;
  logic [PROD_W-1:0] mag_q, mag_d;
  logic [15:0]       bcd_q, bcd_d, bcd_adj;
  logic              sign_q, sign_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              disp_sign_q, disp_sign_d;
  logic [15:0]       disp_bcd_q, disp_bcd_d;
  logic [RW-1:0]     refr_q;
  logic [2:0]        idx_q;
  logic [7:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    disp_sign_d = disp_sign_q;
    disp_bcd_d  = disp_bcd_q;
    bcd_adj     = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      S_IDLE: begin
        if (prod_valid) begin
          sign_d  = product[PROD_W-1];
          mag_d   = product[PROD_W-1] ? (~product + PROD_W'(1)) : product;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'(PROD_W - 1)) state_d = S_LOAD;
      end
      S_LOAD: begin
        disp_sign_d = sign_q;
        disp_bcd_d  = bcd_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Display decode uses the committed registers only, so a conversion in flight is never visible.
  always_comb begin
    an_d  = ~(8'h01 << idx_q);
    seg_d = 7'h7F;
    blank = 1'b0;
`ifdef BPD_LZ_BLANK_EN
    case (idx_q)
      3'd1:    blank = (disp_bcd_q[15:4] == 12'd0);
      3'd2:    blank = (disp_bcd_q[15:8] == 8'd0);
      3'd3:    blank = (disp_bcd_q[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    if (idx_q == 3'd4)  seg_d = disp_sign_q ? 7'h3F : 7'h7F;
    else if (!blank)    seg_d = seg7(disp_bcd_q[{idx_q[1:0], 2'b00} +: 4]);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mag_q       <= '0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      disp_sign_q <= 1'b0;
      disp_bcd_q  <= '0;
      refr_q      <= '0;
      idx_q       <= '0;
      an_q        <= 8'hFF;
      seg_q       <= 7'h7F;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      disp_sign_q <= disp_sign_d;
      disp_bcd_q  <= disp_bcd_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      if (refr_q == RW'(REFRESH_DIV - 1)) begin
        refr_q <= '0;
        idx_q  <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
      end else begin
        refr_q <= refr_q + RW'(1);
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_booth_product_display.sv
// Scoreboard bench for booth_product_display with a fast scan (REFRESH_DIV=4).
// Honors BPD_LZ_BLANK_EN in its reference model.
module tb_booth_product_display;

  logic        clk;
  logic        rst;
  logic [11:0] product;
  logic        prod_valid;
  logic        busy, done, dp;
  logic [7:0]  an;
  logic [6:0]  seg;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [34:0] sb[$];

  booth_product_display #(.REFRESH_DIV(4), .PROD_W(12)) dut (
    .clk(clk), .rst(rst), .product(product), .prod_valid(prod_valid),
    .busy(busy), .done(done), .an(an), .seg(seg), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  // Expected segments packed {idx4, idx3, idx2, idx1, idx0}.
  function automatic logic [34:0] exp_display(input logic [11:0] p);
    logic [4:0][6:0] r;
    int v, mag;
    int d [4];
    v   = int'($signed(p));
    mag = (v < 0) ? -v : v;
    d[0] = mag % 10;
    d[1] = (mag / 10) % 10;
    d[2] = (mag / 100) % 10;
    d[3] = (mag / 1000) % 10;
    for (int i = 0; i < 4; i++) r[i] = ref_seg(d[i]);
`ifdef BPD_LZ_BLANK_EN
    for (int i = 3; i >= 1; i--) begin
      int hi = 0;
      for (int j = i; j < 4; j++) hi += d[j];
      if (hi == 0) r[i] = 7'h7F;
    end
`endif
    r[4] = (v < 0) ? 7'h3F : 7'h7F;
    return r;
  endfunction

  task automatic read_display(output logic [34:0] got);
    logic [4:0][6:0] g;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] want;
      int t;
      want = ~(8'h01 << i);
      t = 0;
      while (an !== want && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) check("scan_timeout", an, want);
      g[i] = seg;
      check("dp_off", dp, 1'b1);
    end
    got = g;
  endtask

  // Leaves the caller at the negedge right after the capturing edge.
  task automatic start_conv(input logic [11:0] p);
    @(negedge clk);
    product    = p;
    prod_valid = 1'b1;
    sb.push_back(exp_display(p));
    @(negedge clk);
    prod_valid = 1'b0;
    check("busy_after_capture", busy, 1'b1);
  endtask

  task automatic wait_done(input int already, input string tag);
    int cycles;
    logic [34:0] got, exp;
    cycles = already;
    while (done !== 1'b1 && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_latency"}, cycles, 13);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 1'b0);
    read_display(got);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      exp = sb.pop_front();
      check({tag, "_display"}, got, exp);
    end
  endtask

  initial begin
    logic [34:0] got;
    logic [7:0]  seq [5] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF};
    int t, base;

    rst = 1'b1; product = '0; prod_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dp", dp, 1'b1);
    rst = 1'b0;

    // Scan order and dwell time.
    t = 0;
    while (an !== 8'hFE && t < 20) begin @(negedge clk); t++; end
    check("scan_first_fe", an, 8'hFE);
    for (int k = 1; k <= 10; k++) begin
      repeat (4) @(negedge clk);
      check("scan_an", an, seq[k % 5]);
      check("scan_upper_off", an[7:5], 3'b111);
    end
    read_display(got);
    check("idle_display", got, exp_display(12'h000));

    // Main conversions.
    start_conv(12'hC20); wait_done(0, "m992");
    start_conv(12'h800); wait_done(0, "m2048");
    start_conv(12'h400); wait_done(0, "p1024");
    start_conv(12'h7FF); wait_done(0, "p2047");
    start_conv(12'h007); wait_done(0, "p7");
    start_conv(12'hFFF); wait_done(0, "m1");

    // Pulse dropped while busy.
    base = done_cnt;
    start_conv(12'h005);
    repeat (3) @(negedge clk);
    product = 12'h3FF; prod_valid = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    wait_done(4, "drop");
    repeat (30) @(negedge clk);
    check("drop_one_done", done_cnt - base, 1);

    // Held prod_valid retriggers each time IDLE is reached.
    @(negedge clk);
    product = 12'h07B; prod_valid = 1'b1;
    @(negedge clk);
    base = done_cnt;
    repeat (42) @(negedge clk);
    check("held_retrigger", done_cnt - base, 3);
    prod_valid = 1'b0;
    repeat (20) @(negedge clk);
    read_display(got);
    check("held_display", got, exp_display(12'h07B));

    // Async reset mid-scan.
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst_an", an, 8'hFF);
    check("async_rst_seg", seg, 7'h7F);
    @(negedge clk);
    rst = 1'b0;
    read_display(got);
    check("post_rst_display", got, exp_display(12'h000));

    // Reset during a conversion aborts it.
    base = done_cnt;
    start_conv(12'h123);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    repeat (30) @(negedge clk);
    check("abort_no_done", done_cnt - base, 0);
    read_display(got);
    check("abort_display", got, exp_display(12'h000));
    start_conv(12'h123); wait_done(0, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
